grid_update_rx: RTL and testbench

//  Receives maze-tile updates from the robot's Arduino over an asynchronous 8-bit parallel GPIO bus with strobe.

---
 rtl/grid_pkg.sv | 26 ++
 rtl/grid_update_rx_sync.sv | 70 +++++++
 rtl/grid_update_rx.sv | 191 +++++++++++++++++++
 tb/tb_grid_update_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared tile/FSM types and packet field positions for grid_update_rx
package grid_pkg;

  typedef enum logic [1:0] {
    UNVISITED = 2'd0,
    VISITED   = 2'd1,
    CURRENT   = 2'd2,
    WALL      = 2'd3
  } tile_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  localparam int HDR_BIT    = 7;
  localparam int MARK_BIT   = 6;
  localparam int DEF_GRID_W = 4;
  localparam int DEF_GRID_H = 5;

  function automatic logic is_header(input logic [7:0] b);
    return b[HDR_BIT] && !b[MARK_BIT];
  endfunction

endpackage

// File: rtl/grid_update_rx_sync.sv
// rtl/grid_update_rx_sync.sv - 2-FF synchroniser and strobe high-time filter (module sync_edge_filt)
// Emits a one-cycle accept pulse with the byte captured once per qualified high period.
module sync_edge_filt #(
  parameter int FILT_CYC = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic       acc_valid,
  output logic [7:0] acc_data
);

  localparam int CW = $clog2(FILT_CYC + 1);

  logic [1:0]    strb_q, strb_d;
  logic [7:0]    d1_q, d1_d, d2_q, d2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          acc_valid_q, acc_valid_d;
  logic [7:0]    acc_data_q, acc_data_d;

  always_comb begin
    strb_d      = {strb_q[0], rx_strobe};
    d1_d        = rx_data;
    d2_d        = d1_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    acc_valid_d = 1'b0;
    acc_data_d  = acc_data_q;
    // Only a strobe seen low first re-arms, so one long high period yields one byte.
    if (!strb_q[1]) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == CW'(FILT_CYC - 1)) begin
        acc_valid_d = 1'b1;
        acc_data_d  = d2_q;
        armed_d     = 1'b0;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      strb_q      <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_data_q  <= '0;
    end else begin
      strb_q      <= strb_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      acc_valid_q <= acc_valid_d;
      acc_data_q  <= acc_data_d;
    end
  end

  assign acc_valid = acc_valid_q;
  assign acc_data  = acc_data_q;

endmodule

// File: rtl/grid_update_rx.sv
// rtl/grid_update_rx.sv - maze-tile packet receiver with tile map and registered read port
// Optional packet parity check enabled by defining GRID_RX_PARITY_EN.
module grid_update_rx
  import grid_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int FILT_CYC = 4,
  parameter int TIMEOUT  = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  input  logic [2:0] rd_x,
  input  logic [2:0] rd_y,
  output logic [1:0] rd_tile,
  output logic       upd_valid,
  output logic [2:0] upd_x,
  output logic [2:0] upd_y,
  output logic [1:0] upd_tile,
  output logic       pkt_err,
  output logic       busy
);

  localparam int NCELL = GRID_W * GRID_H;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  logic       acc_valid;
  logic [7:0] acc_data;

  sync_edge_filt #(.FILT_CYC(FILT_CYC)) u_sync (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe),
    .acc_valid (acc_valid),
    .acc_data  (acc_data)
  );

  state_t        state_q, state_d;
  logic [2:0]    x_q, x_d, y_q, y_d;
  logic [7:0]    data_q, data_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d, busy_q, busy_d;
  logic [1:0]    grid_q [NCELL];
  logic [1:0]    grid_d [NCELL];
  logic          cur_valid_q, cur_valid_d;
  logic [2:0]    cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic          upd_valid_q, upd_valid_d;
  logic [2:0]    upd_x_q, upd_x_d, upd_y_q, upd_y_d;
  logic [1:0]    upd_tile_q, upd_tile_d, rd_tile_q, rd_tile_d;
  logic          par_ok, in_range, rd_in_range, same_pos;
  logic [IW-1:0] wr_idx, cur_idx, rd_idx;

`ifdef GRID_RX_PARITY_EN
  assign par_ok = ~^{2'b10, y_q, x_q, data_q};
`else
  logic unused_data;
  assign par_ok      = 1'b1;
  assign unused_data = ^data_q[7:2];
`endif

  assign in_range    = (int'(x_q) < GRID_W) && (int'(y_q) < GRID_H);
  assign rd_in_range = (int'(rd_x) < GRID_W) && (int'(rd_y) < GRID_H);
  assign same_pos    = (cur_x_q == x_q) && (cur_y_q == y_q);
  assign wr_idx      = IW'(int'(y_q) * GRID_W + int'(x_q));
  assign cur_idx     = IW'(int'(cur_y_q) * GRID_W + int'(cur_x_q));
  assign rd_idx      = IW'(int'(rd_y) * GRID_W + int'(rd_x));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    data_d      = data_q;
    timer_d     = timer_q;
    err_d       = err_q;
    grid_d      = grid_q;
    cur_valid_d = cur_valid_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    upd_valid_d = 1'b0;
    upd_x_d     = upd_x_q;
    upd_y_d     = upd_y_q;
    upd_tile_d  = upd_tile_q;
    case (state_q)
      S_IDLE: begin
        if (acc_valid) begin
          if (is_header(acc_data)) begin
            x_d     = acc_data[2:0];
            y_d     = acc_data[5:3];
            timer_d = '0;
            state_d = S_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        // Any non-header byte completes the packet; a fresh header restarts it.
        if (acc_valid) begin
          if (is_header(acc_data)) begin
            x_d     = acc_data[2:0];
            y_d     = acc_data[5:3];
            timer_d = '0;
            err_d   = 1'b1;
          end else begin
            data_d  = acc_data;
            state_d = S_COMMIT;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
        if (!in_range || !par_ok) begin
          err_d = 1'b1;
        end else begin
          grid_d[wr_idx] = data_q[1:0];
          upd_valid_d    = 1'b1;
          upd_x_d        = x_q;
          upd_y_d        = y_q;
          upd_tile_d     = data_q[1:0];
          if (data_q[1:0] == CURRENT) begin
            if (cur_valid_q && !same_pos) grid_d[cur_idx] = VISITED;
            cur_valid_d = 1'b1;
            cur_x_d     = x_q;
            cur_y_d     = y_q;
          end else if (cur_valid_q && same_pos) begin
            cur_valid_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d    = (state_d == S_DATA);
    rd_tile_d = rd_in_range ? grid_q[rd_idx] : 2'd0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      data_q      <= '0;
      timer_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      grid_q      <= '{default: 2'd0};
      cur_valid_q <= 1'b0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_x_q     <= '0;
      upd_y_q     <= '0;
      upd_tile_q  <= '0;
      rd_tile_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      grid_q      <= grid_d;
      cur_valid_q <= cur_valid_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      upd_valid_q <= upd_valid_d;
      upd_x_q     <= upd_x_d;
      upd_y_q     <= upd_y_d;
      upd_tile_q  <= upd_tile_d;
      rd_tile_q   <= rd_tile_d;
    end
  end

  assign rd_tile   = rd_tile_q;
  assign upd_valid = upd_valid_q;
  assign upd_x     = upd_x_q;
  assign upd_y     = upd_y_q;
  assign upd_tile  = upd_tile_q;
  assign pkt_err   = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_grid_update_rx.sv
// tb/tb_grid_update_rx.sv - scoreboard bench for grid_update_rx against a packet-level map model
module tb_grid_update_rx;

  localparam int GW = 4;
  localparam int GH = 5;
  localparam int TO = 300;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strobe = 1'b0;
  logic [2:0] rd_x = 3'd0, rd_y = 3'd0;
  logic [1:0] rd_tile, upd_tile;
  logic       upd_valid, pkt_err, busy;
  logic [2:0] upd_x, upd_y;

  grid_update_rx #(.GRID_W(GW), .GRID_H(GH), .FILT_CYC(4), .TIMEOUT(TO)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_tile   (rd_tile),
    .upd_valid (upd_valid),
    .upd_x     (upd_x),
    .upd_y     (upd_y),
    .upd_tile  (upd_tile),
    .pkt_err   (pkt_err),
    .busy      (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {logic [2:0] x; logic [2:0] y; logic [1:0] t;} upd_t;
  typedef struct {int c; logic [1:0] t;} rd_t;
  upd_t uq[$];
  rd_t  rq[$];

  // Reference model: map as a 2-D array, packet decode at byte granularity.
  logic [1:0] m_grid[GH][GW];
  bit         m_pend, m_err, m_cv;
  int         m_x, m_y, m_cx, m_cy;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    foreach (m_grid[y, x]) m_grid[y][x] = 2'd0;
    m_pend = 0; m_err = 0; m_cv = 0;
  endfunction

  function automatic void m_commit(logic [7:0] b);
    bit ok = (m_x < GW) && (m_y < GH);
    logic [1:0] t = b[1:0];
`ifdef GRID_RX_PARITY_EN
    logic [15:0] pkt = {2'b10, 3'(m_y), 3'(m_x), b};
    if ($countones(pkt) % 2 != 0) ok = 0;
`endif
    if (!ok) begin
      m_err = 1;
      return;
    end
    if (t == 2'd2) begin
      if (m_cv && (m_cx != m_x || m_cy != m_y)) m_grid[m_cy][m_cx] = 2'd1;
      m_cv = 1; m_cx = m_x; m_cy = m_y;
    end else if (m_cv && m_cx == m_x && m_cy == m_y) begin
      m_cv = 0;
    end
    m_grid[m_y][m_x] = t;
    uq.push_back('{x: 3'(m_x), y: 3'(m_y), t: t});
  endfunction

  function automatic void m_byte(logic [7:0] b);
    if (b[7] && !b[6]) begin
      if (m_pend) m_err = 1;
      m_pend = 1; m_x = int'(b[2:0]); m_y = int'(b[5:3]);
    end else if (!m_pend) begin
      m_err = 1;
    end else begin
      m_pend = 0;
      m_commit(b);
    end
  endfunction

  upd_t mon_u;
  rd_t  mon_r;
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (upd_valid) begin
        if (uq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL upd_unexpected: got pulse (%0d,%0d,%0d) expected none", upd_x, upd_y, upd_tile);
        end else begin
          mon_u = uq.pop_front();
          chk("upd_x", upd_x, mon_u.x);
          chk("upd_y", upd_y, mon_u.y);
          chk("upd_tile", upd_tile, mon_u.t);
        end
      end
      if (rq.size() > 0 && rq[0].c < cyc) begin
        mon_r = rq.pop_front();
        chk("rd_tile", rd_tile, mon_r.t);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    m_byte(b);
    rx_data = b;
    tick(3);
    rx_strobe = 1'b1;
    tick(6);
    rx_strobe = 1'b0;
    tick(8);
  endtask

  task automatic glitch(logic [7:0] b, int len);
    rx_data = b;
    tick(3);
    rx_strobe = 1'b1;
    tick(len);
    rx_strobe = 1'b0;
    tick(8);
  endtask

  task automatic sweep();
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        rd_x = 3'(x);
        rd_y = 3'(y);
        if (x < GW && y < GH) rq.push_back('{c: cyc, t: m_grid[y][x]});
        else rq.push_back('{c: cyc, t: 2'd0});
        tick(1);
      end
    end
    tick(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    m_reset();
    tick(5);
    reset = 1'b0;
    tick(2);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_upd", {upd_x, upd_y, upd_tile}, 0);
    sweep();

    send_byte(8'h8A);
    chk("busy_after_hdr", busy, 1);
    send_byte(8'h02);
    chk("busy_after_data", busy, 0);
    sweep();
    send_byte(8'h8B);
    send_byte(8'h02);
    sweep();
    chk("pkt_err_clean", pkt_err, m_err);
    send_byte(8'hA4);
    send_byte(8'h03);
    chk("pkt_err_oor", pkt_err, m_err);
    sweep();

    do_reset();
    send_byte(8'h80);
    chk("busy_wait", busy, 1);
    tick(TO - 60);
    send_byte(8'h03);
    chk("pkt_err_late_ok", pkt_err, m_err);
    send_byte(8'h80);
    tick(TO + 10);
    m_pend = 0;
    m_err = 1;
    chk("busy_timeout", busy, 0);
    chk("pkt_err_timeout", pkt_err, m_err);
    send_byte(8'h01);
    sweep();

    do_reset();
    glitch(8'h81, 2);
    send_byte(8'h01);
    chk("pkt_err_glitch", pkt_err, m_err);
    send_byte(8'h8A);
    do_reset();
    chk("pkt_err_midrst", pkt_err, 0);
    chk("busy_midrst", busy, 0);
    send_byte(8'h02);
    chk("pkt_err_orphan", pkt_err, m_err);
    sweep();

    do_reset();
    send_byte(8'h81); send_byte(8'h01);
    chk("pkt_err_par_a", pkt_err, m_err);
    send_byte(8'h81); send_byte(8'h41);
    chk("pkt_err_par_b", pkt_err, m_err);
    sweep();

    do_reset();
    for (int i = 0; i < 120; i++) begin
      int sel = $urandom_range(0, 19);
      logic [7:0] hdr = {2'b10, 3'($urandom_range(0, 5)), 3'($urandom_range(0, 4))};
      logic [1:0] t = ($urandom_range(0, 9) < 4) ? 2'd2 : 2'($urandom_range(0, 3));
      logic [7:0] dat = {1'b0, 1'($urandom_range(0, 1)), 4'b0000, t};
      if (sel == 0) begin
        glitch(8'($urandom), $urandom_range(1, 3));
      end else if (sel == 1) begin
        send_byte(dat);
      end else if (sel == 2) begin
        send_byte({2'b10, 3'($urandom_range(0, 4)), 3'($urandom_range(0, 3))});
        send_byte(hdr);
        send_byte(dat);
      end else begin
        send_byte(hdr);
        send_byte(dat);
      end
      chk("pkt_err_rand", pkt_err, m_err);
      if (i % 20 == 19) sweep();
    end
    sweep();

    tick(20);
    chk("upd_queue_drained", uq.size(), 0);
    chk("rd_queue_drained", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
